// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU MEM stage
// and a multi-cycle data RAM. Read hits are served combinationally; misses and writes stall.
module dcache_dm #(
  parameter int INDEX_WIDTH = 3,
  parameter int TAG_WIDTH   = 32 - INDEX_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_stall
);

  localparam int LINES = 2 ** INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tags [LINES];
  logic [31:0]            data [LINES];
  logic [31:0]            result;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   hit;
  logic [INDEX_WIDTH-1:0] lat_idx;
  logic [TAG_WIDTH-1:0]   lat_tag;
  logic                   lat_hit;

  assign idx = cpu_addr[INDEX_WIDTH-1:0];
  assign tag = cpu_addr[31:INDEX_WIDTH];
  assign hit = valid[idx] && (tags[idx] == tag);

  // mem_addr/mem_din double as the latched request, so input changes mid-transfer are ignored
  assign lat_idx = mem_addr[INDEX_WIDTH-1:0];
  assign lat_tag = mem_addr[31:INDEX_WIDTH];
  assign lat_hit = valid[lat_idx] && (tags[lat_idx] == lat_tag);

  always_comb begin
    cpu_stall = 1'b0;
    cpu_dout  = '0;
    case (state)
      IDLE: begin
        if (cpu_cs) begin
          if (cpu_we || !hit) cpu_stall = 1'b1;
          else                cpu_dout  = data[idx];
        end
      end
      RD_MISS, WR_THRU: cpu_stall = 1'b1;
      DONE:             cpu_dout  = result;
      default: ;
    endcase
  end

  // A transfer completes on the first posedge in RD_MISS/WR_THRU with mem_stall low
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_cs && (cpu_we || !hit)) begin
            mem_cs   <= 1'b1;
            mem_we   <= cpu_we;
            mem_addr <= cpu_addr;
            if (cpu_we) mem_din <= cpu_din;
            state    <= cpu_we ? WR_THRU : RD_MISS;
          end
        end
        RD_MISS: begin
          if (!mem_stall) begin
            valid[lat_idx] <= 1'b1;
            tags[lat_idx]  <= lat_tag;
            data[lat_idx]  <= mem_dout;
            result         <= mem_dout;
            mem_cs         <= 1'b0;
            mem_we         <= 1'b0;
            state          <= DONE;
          end
        end
        WR_THRU: begin
          if (!mem_stall) begin
            if (lat_hit) data[lat_idx] <= mem_din;
            result <= '0;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed vector table, hand-written reset and
// input-disturbance sequences, then random traffic checked against a line-level model.
module tb_dcache_dm;

  logic        clk;
  logic        rst;
  logic        cpu_cs;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_stall;

  dcache_dm #(.INDEX_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_stall(mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // RAM model: mem_stall stays high for ram_wait cycles of each request
  logic [31:0] ram [256];
  int          ram_wait = 0;
  int          cnt = 0;

  assign mem_stall = mem_cs && (cnt < ram_wait);
  assign mem_dout  = ram[mem_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
    ram[5] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (mem_cs && mem_we && !mem_stall) ram[mem_addr[7:0]] <= mem_din;
      if (!mem_cs)        cnt <= 0;
      else if (mem_stall) cnt <= cnt + 1;
    end
  end

  // Bus monitor: counts request bursts and any drift of the held request fields
  int          bursts = 0;
  int          hold_err = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_din = '0;

  initial begin
    logic last_cs;
    last_cs = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_cs && !last_cs) bursts++;
      if (mem_cs && (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_din !== exp_din)))
        hold_err++;
      last_cs = mem_cs;
    end
  end

  // Reference model: cache lines and RAM contents at word/line granularity
  bit          model_valid [8];
  int          model_tag   [8];
  logic [31:0] model_data  [8];
  logic [31:0] ref_mem     [256];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] din,
                              input int wt, output int e_stall, output logic [31:0] e_dout,
                              output int e_bursts);
    int  line;
    bit  is_hit;
    line   = int'(addr % 8);
    is_hit = model_valid[line] && (model_tag[line] == int'(addr / 8));
    if (!we && is_hit) begin
      e_stall  = 0;
      e_dout   = model_data[line];
      e_bursts = 0;
    end else if (!we) begin
      e_stall  = wt + 2;
      e_dout   = ref_mem[addr[7:0]];
      e_bursts = 1;
      model_valid[line] = 1'b1;
      model_tag[line]   = int'(addr / 8);
      model_data[line]  = ref_mem[addr[7:0]];
    end else begin
      e_stall  = wt + 2;
      e_dout   = '0;
      e_bursts = 1;
      ref_mem[addr[7:0]] = din;
      if (is_hit) model_data[line] = din;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
  endtask

  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] din,
                                input int wt, input bit disturb,
                                output int stall_cycles, output logic [31:0] dout,
                                output int nbursts, output int nhold, output logic done_cs);
    int b0, h0;
    b0 = bursts;
    h0 = hold_err;
    ram_wait = wt;
    exp_we = we; exp_addr = addr; exp_din = din;
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    stall_cycles = 0;
    @(negedge clk);
    while (cpu_stall && stall_cycles < 100) begin
      stall_cycles++;
      if (disturb && stall_cycles == 2) begin
        cpu_addr = addr ^ 32'h1F;
        cpu_din  = ~din;
      end
      @(negedge clk);
    end
    dout    = cpu_dout;
    done_cs = mem_cs;
    @(posedge clk);
    #1;
    cpu_cs  = 1'b0;
    nbursts = bursts - b0;
    nhold   = hold_err - h0;
  endtask

  task automatic run_access(input string name, input logic we, input logic [31:0] addr,
                            input logic [31:0] din, input int wt, input bit disturb,
                            input bit use_table, input int t_stall, input logic [31:0] t_dout,
                            input int t_bursts);
    int          e_stall, e_bursts, g_stall, g_bursts, g_hold;
    logic [31:0] e_dout, g_dout;
    logic        g_cs;
    model_access(we, addr, din, wt, e_stall, e_dout, e_bursts);
    if (use_table) begin
      e_stall = t_stall; e_dout = t_dout; e_bursts = t_bursts;
    end
    apply_stimulus(we, addr, din, wt, disturb, g_stall, g_dout, g_bursts, g_hold, g_cs);
    check_output({name, " stall_cycles"}, g_stall, e_stall);
    check_output({name, " cpu_dout"}, g_dout, e_dout);
    check_output({name, " mem_cs_bursts"}, g_bursts, e_bursts);
    check_output({name, " mem_req_held"}, g_hold, 0);
    check_output({name, " mem_cs_at_retire"}, {31'b0, g_cs}, 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    int          wt;
    int          exp_stall;
    logic [31:0] exp_dout;
    int          exp_bursts;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b0, 32'h05, 32'h0,         8, 10, 32'hDEAD_BEEF, 1};
    vecs[1] = '{1'b0, 32'h05, 32'h0,         0,  0, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1'b1, 32'h05, 32'h1234_5678, 2,  4, 32'h0,         1};
    vecs[3] = '{1'b0, 32'h05, 32'h0,         0,  0, 32'h1234_5678, 0};
    vecs[4] = '{1'b1, 32'h0D, 32'hCAFE_F00D, 1,  3, 32'h0,         1};
    vecs[5] = '{1'b0, 32'h05, 32'h0,         0,  0, 32'h1234_5678, 0};
    vecs[6] = '{1'b0, 32'h0D, 32'h0,         0,  2, 32'hCAFE_F00D, 1};
    vecs[7] = '{1'b0, 32'h02, 32'h0,         1,  3, 32'h1000_0002, 1};
    vecs[8] = '{1'b0, 32'h0A, 32'h0,         0,  2, 32'h1000_000A, 1};
    vecs[9] = '{1'b0, 32'h02, 32'h0,         0,  2, 32'h1000_0002, 1};

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + i;
    ref_mem[5] = 32'hDEAD_BEEF;
    model_reset();

    rst = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset cpu_stall", {31'b0, cpu_stall}, 0);
    check_output("reset cpu_dout", cpu_dout, 0);
    check_output("reset mem_cs", {31'b0, mem_cs}, 0);
    check_output("reset mem_addr", mem_addr, 0);
    check_output("reset mem_din", mem_din, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      run_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].wt,
                 1'b0, 1'b1, vecs[i].exp_stall, vecs[i].exp_dout, vecs[i].exp_bursts);

    // Reset during the 4th RD_MISS cycle abandons the fill
    run_access("pre_rst_fill", 1'b0, 32'h05, 32'h0, 0, 1'b0, 1'b0, 0, 0, 0);
    run_access("pre_rst_evict", 1'b0, 32'h0D, 32'h0, 0, 1'b0, 1'b0, 0, 0, 0);
    ram_wait = 10;
    exp_we = 1'b0; exp_addr = 32'h05; exp_din = '0;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h05; cpu_din = '0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_cs = 1'b0;
    @(negedge clk);
    check_output("rst_mid mem_cs before edge", {31'b0, mem_cs}, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_mid mem_cs after", {31'b0, mem_cs}, 0);
    check_output("rst_mid mem_addr after", mem_addr, 0);
    check_output("rst_mid cpu_stall after", {31'b0, cpu_stall}, 0);
    @(posedge clk);
    #1;
    model_reset();
    run_access("post_rst_read05", 1'b0, 32'h05, 32'h0, 1, 1'b0, 1'b0, 0, 0, 0);

    // Input address changes mid-miss: fill must go to the latched line
    run_access("disturb_read03", 1'b0, 32'h03, 32'h0, 4, 1'b1, 1'b0, 0, 0, 0);
    run_access("disturb_rehit03", 1'b0, 32'h03, 32'h0, 0, 1'b0, 1'b0, 0, 0, 0);
    run_access("disturb_miss1c", 1'b0, 32'h1C, 32'h0, 0, 1'b0, 1'b0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cpu_cs = 1'b0;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom_range(0, 31);
        @(negedge clk);
        check_output("idle cpu_stall", {31'b0, cpu_stall}, 0);
        check_output("idle cpu_dout", cpu_dout, 0);
        check_output("idle mem_cs", {31'b0, mem_cs}, 0);
        @(posedge clk);
        #1;
      end
      run_access($sformatf("rand%0d", n), 1'($urandom_range(0, 2) == 0),
                 32'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3),
                 1'b0, 1'b0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Direct-mapped, write-through, no-write-allocate data cache placed between the CPU MEM stage and the multi-cycle data RAM. Read hits return data in the same cycle with no stall. Misses and all writes are forwarded to the RAM using its `cs`/`we`/`addr`/`din`/`dout` interface. The RAM's level `ram_stall` paces each transfer, and `cpu_stall` freezes the pipeline until the transfer completes.

## Interface
Parameters:
- `INDEX_WIDTH`, 3: line index bits; `2**INDEX_WIDTH` lines of one 32-bit word each.
- `TAG_WIDTH`, `32-INDEX_WIDTH`: tag bits stored per line.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_cs`  in  1  CPU access request.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  word address; index = `[INDEX_WIDTH-1:0]`, tag = `[31:INDEX_WIDTH]`.
- `cpu_din`  in  32  write data.
- `cpu_dout`  out  32  read data, combinational.
- `cpu_stall`  out  1  pipeline stall, combinational.
- `mem_cs`  out  1  RAM chip select, registered.
- `mem_we`  out  1  RAM write enable, registered.
- `mem_addr`  out  32  RAM word address, registered.
- `mem_din`  out  32  RAM write data, registered.
- `mem_dout`  in  32  RAM read data.
- `mem_stall`  in  1  RAM busy. Transfer completes on a posedge where `mem_cs=1` and `mem_stall=0`.

## Operation
- Storage per line: `valid`, tag, and a 32-bit data word.
- `hit` = `valid[idx]` and `tag[idx] == cpu_addr[31:INDEX_WIDTH]`.
- States: IDLE, RD_MISS, WR_THRU, DONE.
- **IDLE**
  - `cpu_cs & !cpu_we & hit`: `cpu_dout = data[idx]`, `cpu_stall=0`, stay in IDLE.
  - `cpu_cs & !cpu_we & !hit`: `cpu_stall=1`. Latch address. Next state RD_MISS with `mem_cs=1`, `mem_we=0`, `mem_addr=cpu_addr`.
  - `cpu_cs & cpu_we`: `cpu_stall=1`. Latch address and data. Next state WR_THRU with `mem_cs=1`, `mem_we=1`, `mem_addr=cpu_addr`, `mem_din=cpu_din`.
  - `!cpu_cs`: `cpu_stall=0`, `cpu_dout=0`.
- **RD_MISS**
  - `cpu_stall=1`; mem outputs held constant.
  - On completion: line[idx] gets {valid=1, latched tag, `mem_dout`}. Result register gets `mem_dout`. Drop `mem_cs`/`mem_we` to 0. Next state DONE.
- **WR_THRU**
  - `cpu_stall=1`; mem outputs held.
  - On completion: if the latched address hits, line data is updated with the latched data. A miss leaves the cache unchanged (no allocate).
  - Drop `mem_cs`/`mem_we`. Next state DONE.
- **DONE**
  - `cpu_stall=0`, `cpu_dout` = result register (0 after a write). `mem_cs=0`.
  - Next state IDLE unconditionally. This is the single cycle in which the CPU retires the stalled access.
- CPU inputs must be held stable while `cpu_stall=1`. The cache nevertheless operates only on the latched copy; input changes during RD_MISS/WR_THRU are ignored.
- A read to the same index with a different tag evicts the line. No write-back is needed.

## Timing
- Reset, applied at any posedge including mid-transfer:
  - state = IDLE, all `valid` = 0.
  - `mem_cs=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`, result register = 0.
  - An in-flight transfer is abandoned and no line is written.
- Read hit: 0 stall cycles; data valid in the same cycle as `cpu_cs`.
- Read miss or write: `cpu_stall` high for 1 (IDLE detect) + K cycles, where K is the number of cycles spent in RD_MISS/WR_THRU. K is 1 if `mem_stall` is already low. The DONE cycle follows with `cpu_stall=0`.
- `mem_cs` never stays high for more than one cycle past completion. After every transfer there is at least one cycle with `mem_cs=0` (DONE), so the RAM sees a request boundary.
- Back-to-back misses: DONE, IDLE (detect), then RD_MISS. A minimum of 2 cycles separates consecutive `mem_cs` assertions.
- `mem_stall` is ignored when `mem_cs=0`.

## Test plan
- Reset, then read `0x05` with RAM word 5 = `0xDEADBEEF` and `mem_stall` held high for 8 cycles:
  - `cpu_stall` is high for 10 cycles.
  - The DONE cycle shows `cpu_dout=0xDEADBEEF`.
  - An immediate re-read of `0x05` returns `0xDEADBEEF` with `cpu_stall=0` and no `mem_cs`.
- Write `0x05` with `0x12345678` after line 5 has been filled:
  - `mem_we=1`, `mem_addr=0x05`, `mem_din=0x12345678` until completion.
  - A following read hits and returns `0x12345678`.
- Write miss to `0x0D` (index 5, line holds tag 0):
  - RAM is written.
  - A read of `0x05` still hits its old data.
  - A read of `0x0D` misses and fetches from RAM.
- Conflict: read `0x02`, then `0x0A`, then `0x02`. All three miss, each with exactly one `mem_cs` burst.
- Assert `rst` in the 4th cycle of RD_MISS:
  - `mem_cs` goes low the next cycle.
  - A subsequent read of the same address misses.
- `cpu_addr` changes while stalled in RD_MISS: `mem_addr` stays at the latched value and the line filled is the latched index.
